sseg_scan_driver: RTL and testbench

//  Consumer of the 4-digit display bus (digit0..digit3 + ltr_flag) produced by the

---
 rtl/sseg_scan_driver.sv | 176 +++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/sseg_scan_driver.sv
// Four-digit common-anode 7-segment scan driver.
// Latches one digit set per frame; decodes, scans, blanks and dims it.
module sseg_scan_driver #(
  parameter int REFRESH_DIV = 100_000,
  parameter int BLANK_CYC   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic [3:0] digit2,
  input  logic [3:0] digit3,
  input  logic       ltr_flag,
  input  logic [3:0] dp_en,
  input  logic [3:0] brightness,
  output logic [3:0] an,
  output logic [7:0] sseg,
  output logic       frame_tick
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic [CW-1:0] SLOT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYC);

  // Glyphs, active-low {g,f,e,d,c,b,a}
  localparam logic [6:0] G_0     = 7'h40;
  localparam logic [6:0] G_1     = 7'h79;
  localparam logic [6:0] G_2     = 7'h24;
  localparam logic [6:0] G_3     = 7'h30;
  localparam logic [6:0] G_4     = 7'h19;
  localparam logic [6:0] G_5     = 7'h12;
  localparam logic [6:0] G_6     = 7'h02;
  localparam logic [6:0] G_7     = 7'h78;
  localparam logic [6:0] G_8     = 7'h00;
  localparam logic [6:0] G_9     = 7'h10;
  localparam logic [6:0] G_DASH  = 7'h3F;
  localparam logic [6:0] G_H     = 7'h09;
  localparam logic [6:0] G_I     = 7'h79;
  localparam logic [6:0] G_E     = 7'h06;
  localparam logic [6:0] G_O     = 7'h40;
  localparam logic [6:0] G_R     = 7'h2F;
  localparam logic [6:0] G_BLANK = 7'h7F;

  typedef enum logic {
    ST_LOAD,
    ST_SCAN
  } state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     slot_q, slot_d;
  logic [1:0]        idx_q, idx_d;
  logic [3:0][3:0]   dig_q, dig_d;
  logic              ltr_q, ltr_d;
  logic [3:0]        dp_q, dp_d;
  logic [3:0]        an_q, an_d;
  logic [7:0]        sseg_q, sseg_d;
  logic              tick_q, tick_d;

  logic              load;
  logic [3:0]        code;
  logic [6:0]        glyph;
  logic              blank;
  logic              lit;

  // Scan sequencing and frame-boundary shadow capture
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    idx_d   = idx_q;
    load    = 1'b0;
    unique case (state_q)
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (slot_q == SLOT_LAST) begin
          slot_d = '0;
          idx_d  = idx_q + 2'd1;
          load   = (idx_q == 2'd3);
        end else begin
          slot_d = slot_q + CW'(1);
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_comb begin
    dig_d  = dig_q;
    ltr_d  = ltr_q;
    dp_d   = dp_q;
    tick_d = 1'b0;
    if (load) begin
      dig_d  = {digit3, digit2, digit1, digit0};
      ltr_d  = ltr_flag;
      dp_d   = dp_en;
      tick_d = 1'b1;
    end
  end

  assign code = dig_q[idx_q];

  always_comb begin
    glyph = G_BLANK;
    if (!ltr_q) begin
      unique case (code)
        4'h0: glyph = G_0;
        4'h1: glyph = G_1;
        4'h2: glyph = G_2;
        4'h3: glyph = G_3;
        4'h4: glyph = G_4;
        4'h5: glyph = G_5;
        4'h6: glyph = G_6;
        4'h7: glyph = G_7;
        4'h8: glyph = G_8;
        4'h9: glyph = G_9;
        4'hA, 4'hB, 4'hC,
        4'hD, 4'hE: glyph = G_DASH;
        default: glyph = G_BLANK;
      endcase
    end else begin
      unique case (code)
        4'h5: glyph = G_H;
        4'hA: glyph = G_I;
        4'hE: glyph = G_E;
        4'h0: glyph = G_O;
        4'h9: glyph = G_R;
        default: glyph = G_BLANK;
      endcase
    end
  end

  assign blank = (glyph == G_BLANK);

  // PWM window starts after the anti-ghost gap of each slot
  assign lit = (slot_q >= BLANK_LIM) &&
               (slot_q[3:0] <= brightness);

  always_comb begin
    an_d = 4'hF;
    if (lit) begin
      an_d[idx_q] = 1'b0;
    end
    sseg_d = {~(dp_q[idx_q] & ~blank), glyph};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_LOAD;
      slot_q  <= '0;
      idx_q   <= 2'd0;
      dig_q   <= {4{4'hF}};
      ltr_q   <= 1'b0;
      dp_q    <= 4'h0;
      an_q    <= 4'hF;
      sseg_q  <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      dig_q   <= dig_d;
      ltr_q   <= ltr_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      sseg_q  <= sseg_d;
      tick_q  <= tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Bench for sseg_scan_driver: vector table, corner sequences, random vs model.
// Model works from absolute cycle position within a 128-cycle frame.
module tb_sseg_scan_driver;

  localparam int RD = 32;
  localparam int BC = 4;
  localparam int FR = 4 * RD;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] d0, d1, d2, d3;
  logic       ltr;
  logic [3:0] dpe;
  logic [3:0] br;
  logic [3:0] an;
  logic [7:0] sseg;
  logic       ft;

  sseg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk(clk), .rst(rst),
    .digit0(d0), .digit1(d1), .digit2(d2), .digit3(d3),
    .ltr_flag(ltr), .dp_en(dpe), .brightness(br),
    .an(an), .sseg(sseg), .frame_tick(ft)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  string num_t[10] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                       "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};

  // model state
  logic [3:0] m_dig[4];
  logic       m_ltr;
  logic [3:0] m_dp;
  bit         m_loaded;
  int         m_n;
  int         cur_pos;

  function automatic logic [6:0] segs(string s);
    logic [6:0] r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  function automatic string lit_of(logic [3:0] c, logic l);
    if (!l) begin
      if (c <= 4'd9) return num_t[c];
      if (c == 4'hF) return "";
      return "g";
    end
    case (c)
      4'h5: return "bcefg";
      4'hA: return "bc";
      4'hE: return "adefg";
      4'h0: return "abcdef";
      4'h9: return "eg";
      default: return "";
    endcase
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [3:0] cd[4];
    logic cl, crst;
    logic [3:0] cdp, cb;
    logic [3:0] ean;
    logic [7:0] esg;
    logic eft;
    int p;
    bit ld;
    string s;
    logic [6:0] g;
    cd[0] = d0; cd[1] = d1; cd[2] = d2; cd[3] = d3;
    cl = ltr; cdp = dpe; cb = br; crst = rst;
    @(posedge clk);
    if (crst) begin
      ean = 4'hF; esg = 8'hFF; eft = 1'b0;
      m_loaded = 0; m_n = 0; cur_pos = 0;
      for (int i = 0; i < 4; i++) m_dig[i] = 4'hF;
      m_ltr = 1'b0; m_dp = 4'h0;
    end else begin
      if (!m_loaded) begin
        p = 0; ld = 1; m_loaded = 1; m_n = 0;
      end else begin
        p = m_n % FR; m_n++; ld = (m_n % FR == 0);
      end
      ean = 4'hF;
      if ((p % RD) >= BC && ((p % RD) % 16) <= int'(cb))
        ean[p / RD] = 1'b0;
      s = lit_of(m_dig[p / RD], m_ltr);
      g = segs(s);
      esg = {~(m_dp[p / RD] && s.len() != 0), g};
      eft = ld;
      if (ld) begin
        for (int i = 0; i < 4; i++) m_dig[i] = cd[i];
        m_ltr = cl; m_dp = cdp;
      end
      cur_pos = m_n % FR;
    end
    #1;
    check("an", {28'd0, an}, {28'd0, ean});
    check("sseg", {24'd0, sseg}, {24'd0, esg});
    check("frame_tick", {31'd0, ft}, {31'd0, eft});
  endtask

  task automatic run_until(int pos);
    int k = 0;
    while (cur_pos != pos && k < 400) begin
      step();
      k++;
    end
    checks++;
    if (cur_pos != pos) begin
      errs++;
      $display("FAIL reach_pos: got %0d want %0d", cur_pos, pos);
    end
  endtask

  task automatic set_in(logic [15:0] dg, logic l, logic [3:0] dp);
    d0 = dg[3:0]; d1 = dg[7:4]; d2 = dg[11:8]; d3 = dg[15:12];
    ltr = l; dpe = dp;
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [15:0] dg;
    logic        l;
    logic [3:0]  dp;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[5];
  int   cnt;
  int   k;

  initial begin
    vecs[0] = '{dg: 16'h4321, l: 1'b0, dp: 4'h0, exp: 32'h99B0A4F9};
    vecs[1] = '{dg: 16'hFF5A, l: 1'b1, dp: 4'h0, exp: 32'hFFFF89F9};
    vecs[2] = '{dg: 16'h30E9, l: 1'b1, dp: 4'h0, exp: 32'hFFC086AF};
    vecs[3] = '{dg: 16'h08FB, l: 1'b0, dp: 4'hF, exp: 32'h4000FF3F};
    vecs[4] = '{dg: 16'h0500, l: 1'b0, dp: 4'h4, exp: 32'hC012C0C0};

    rst = 1'b1;
    br = 4'hF;
    set_in(16'h4321, 1'b0, 4'h0);
    m_loaded = 0; m_n = 0; cur_pos = 0;

    // reset held 3 cycles, first tick one cycle after release
    do_reset(3);
    check("rst_an", {28'd0, an}, 32'hF);
    check("rst_sseg", {24'd0, sseg}, 32'hFF);
    step();
    check("first_tick", {31'd0, ft}, 32'd1);

    // decode table across all four slots
    foreach (vecs[v]) begin
      set_in(vecs[v].dg, vecs[v].l, vecs[v].dp);
      br = 4'hF;
      do_reset(1);
      for (int i = 0; i < 4; i++) begin
        run_until(i * RD + 20);
        check("tbl_sseg", {24'd0, sseg}, {24'd0, vecs[v].exp[i*8 +: 8]});
        check("tbl_an", {28'd0, an}, {28'd0, ~(4'b0001 << i)});
      end
    end

    // mid-frame input change stays hidden until next frame
    set_in(16'h4321, 1'b0, 4'h0);
    do_reset(1);
    run_until(RD + 5);
    d0 = 4'h7; d2 = 4'h9;
    run_until(2 * RD + 20);
    check("iso_d2", {24'd0, sseg}, 32'hB0);
    k = 0;
    do begin step(); k++; end while (!ft && k < 300);
    k = 0;
    do begin step(); k++; end while (!ft && k < 300);
    check("tick_period", k, FR);
    run_until(20);
    check("new_d0", {24'd0, sseg}, 32'hF8);
    run_until(2 * RD + 20);
    check("new_d2", {24'd0, sseg}, 32'h90);

    // brightness duty per slot
    br = 4'h0;
    run_until(RD);
    cnt = 0;
    repeat (RD) begin step(); if (an == 4'b1101) cnt++; end
    check("duty_b0", cnt, 1);
    br = 4'h7;
    run_until(RD);
    cnt = 0;
    repeat (RD) begin step(); if (an == 4'b1101) cnt++; end
    check("duty_b7", cnt, 12);

    // reset mid-frame, then reload with current inputs
    br = 4'hF;
    run_until(2 * RD + 17);
    set_in(16'h1234, 1'b0, 4'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_an", {28'd0, an}, 32'hF);
    check("mid_rst_sseg", {24'd0, sseg}, 32'hFF);
    step();
    check("mid_rst_tick", {31'd0, ft}, 32'd1);
    run_until(20);
    check("mid_rst_d0", {24'd0, sseg}, 32'h99);

    // random stimulus against the model
    for (int i = 0; i < 1500; i++) begin
      if ($urandom % 16 == 0)
        set_in(16'($urandom), 1'($urandom), 4'($urandom));
      if ($urandom % 32 == 0) br = 4'($urandom);
      rst = ($urandom % 400 == 0);
      step();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
